// File: rtl/wf68k30l_exec_wb_seq.sv
// Registered execute/writeback sequencer: walks register writebacks, then memory write beats
// with optional address-pipeline cycles. Optional abort support: WF68K30L_EXEC_WB_ABORT_EN.
module wf68k30l_exec_wb_seq #(
  parameter int MAX_WB = 2,
  parameter int MAX_WR = 2,
  localparam int WBC_W = $clog2(MAX_WB + 1),
  localparam int WRC_W = $clog2(MAX_WR + 1),
  localparam int WB_IW = (MAX_WB > 1) ? $clog2(MAX_WB) : 1,
  localparam int WR_IW = (MAX_WR > 1) ? $clog2(MAX_WR) : 1
) (
  input  logic             CLK,
  input  logic             RESET_CPU,
  input  logic             ALU_INIT,
  input  logic             ALU_REQ,
  input  logic             HOLD_EXEC,
  input  logic [WBC_W-1:0] WB_CNT_I,
  input  logic [WRC_W-1:0] WR_CNT_I,
  input  logic             ADR_FIRST_I,
  input  logic             ADR_BETWEEN_I,
  input  logic             WR_RDY,
  input  logic             ABORT,
  output logic [2:0]       STATE,
  output logic             BUSY,
  output logic             WB_STB,
  output logic [WB_IW-1:0] WB_IDX,
  output logic             ADR_STB,
  output logic             WR_REQ,
  output logic [WR_IW-1:0] WR_IDX,
  output logic             DONE,
  output logic             ABORTED
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_ADR  = 3'd2,
    S_WB   = 3'd3,
    S_WR   = 3'd4
  } state_t;

  state_t           state_r, state_n;
  logic [WBC_W-1:0] wb_tot_r, wb_tot_n, wb_sat_s;
  logic [WRC_W-1:0] wr_tot_r, wr_tot_n, wr_sat_s;
  logic [WB_IW-1:0] wb_idx_r, wb_idx_n;
  logic [WR_IW-1:0] wr_idx_r, wr_idx_n;
  logic             adr_first_r, adr_first_n, adr_between_r, adr_between_n;
  logic             done_n, aborted_n, abort_s;

`ifdef WF68K30L_EXEC_WB_ABORT_EN
  assign abort_s = ABORT && (state_r != S_IDLE);
`else
  logic unused_abort;
  assign unused_abort = ABORT;
  assign abort_s      = 1'b0;
`endif

  assign STATE = state_r;

  // Next-state, counter and completion decode
  always_comb begin
    state_n       = state_r;
    wb_tot_n      = wb_tot_r;
    wr_tot_n      = wr_tot_r;
    wb_idx_n      = wb_idx_r;
    wr_idx_n      = wr_idx_r;
    adr_first_n   = adr_first_r;
    adr_between_n = adr_between_r;
    done_n        = 1'b0;
    aborted_n     = 1'b0;
    wb_sat_s = (WB_CNT_I > WBC_W'(MAX_WB)) ? WBC_W'(MAX_WB) : WB_CNT_I;
    wr_sat_s = (WR_CNT_I > WRC_W'(MAX_WR)) ? WRC_W'(MAX_WR) : WR_CNT_I;
    case (state_r)
      S_IDLE: begin
        if (ALU_INIT) state_n = S_EXEC;
        else          state_n = S_IDLE;
      end
      S_EXEC: begin
        if (ALU_REQ && !HOLD_EXEC) begin
          wb_tot_n      = wb_sat_s;
          wr_tot_n      = wr_sat_s;
          adr_first_n   = ADR_FIRST_I;
          adr_between_n = ADR_BETWEEN_I;
          wb_idx_n      = {WB_IW{1'b0}};
          wr_idx_n      = {WR_IW{1'b0}};
          if (wb_sat_s != {WBC_W{1'b0}})      state_n = S_WB;
          else if (wr_sat_s != {WRC_W{1'b0}}) state_n = ADR_FIRST_I ? S_ADR : S_WR;
          else begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end
        end else begin
          state_n = S_EXEC;
        end
      end
      S_WB: begin
        if (WBC_W'(wb_idx_r) + WBC_W'(1) == wb_tot_r) begin
          if (wr_tot_r != {WRC_W{1'b0}}) state_n = adr_first_r ? S_ADR : S_WR;
          else begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end
        end else begin
          wb_idx_n = wb_idx_r + WB_IW'(1);
        end
      end
      S_ADR: state_n = S_WR;
      S_WR: begin
        if (WR_RDY) begin
          if (WRC_W'(wr_idx_r) + WRC_W'(1) == wr_tot_r) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end else begin
            wr_idx_n = wr_idx_r + WR_IW'(1);
            state_n  = adr_between_r ? S_ADR : S_WR;
          end
        end else begin
          state_n = S_WR;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // Abort overrides any completion or beat acceptance in the same cycle
    if (abort_s) begin
      state_n   = S_IDLE;
      done_n    = 1'b0;
      aborted_n = 1'b1;
    end else begin
      aborted_n = 1'b0;
    end
    if (state_n == S_IDLE) begin
      wb_tot_n      = {WBC_W{1'b0}};
      wr_tot_n      = {WRC_W{1'b0}};
      wb_idx_n      = {WB_IW{1'b0}};
      wr_idx_n      = {WR_IW{1'b0}};
      adr_first_n   = 1'b0;
      adr_between_n = 1'b0;
    end else begin
      adr_first_n   = adr_first_n;
    end
  end

  // State, counters and registered output decode
  always_ff @(posedge CLK) begin
    if (RESET_CPU) begin
      state_r       <= S_IDLE;
      wb_tot_r      <= {WBC_W{1'b0}};
      wr_tot_r      <= {WRC_W{1'b0}};
      wb_idx_r      <= {WB_IW{1'b0}};
      wr_idx_r      <= {WR_IW{1'b0}};
      adr_first_r   <= 1'b0;
      adr_between_r <= 1'b0;
      BUSY          <= 1'b0;
      WB_STB        <= 1'b0;
      WB_IDX        <= {WB_IW{1'b0}};
      ADR_STB       <= 1'b0;
      WR_REQ        <= 1'b0;
      WR_IDX        <= {WR_IW{1'b0}};
      DONE          <= 1'b0;
      ABORTED       <= 1'b0;
    end else begin
      state_r       <= state_n;
      wb_tot_r      <= wb_tot_n;
      wr_tot_r      <= wr_tot_n;
      wb_idx_r      <= wb_idx_n;
      wr_idx_r      <= wr_idx_n;
      adr_first_r   <= adr_first_n;
      adr_between_r <= adr_between_n;
      BUSY          <= (state_n != S_IDLE);
      WB_STB        <= (state_n == S_WB);
      WB_IDX        <= (state_n == S_WB) ? wb_idx_n : {WB_IW{1'b0}};
      ADR_STB       <= (state_n == S_ADR);
      WR_REQ        <= (state_n == S_WR);
      WR_IDX        <= (state_n == S_WR) ? wr_idx_n : {WR_IW{1'b0}};
      DONE          <= done_n;
      ABORTED       <= aborted_n;
    end
  end

endmodule

// File: tb/tb_wf68k30l_exec_wb_seq.sv
// Self-checking bench for wf68k30l_exec_wb_seq: per-cycle expected traces built from the
// sequencing rules (writebacks, optional ADR cycles, write beats with random ready delay).
module tb_wf68k30l_exec_wb_seq;
  localparam int MAX_WB = 2;
  localparam int MAX_WR = 2;

  logic       CLK = 1'b0;
  logic       RESET_CPU, ALU_INIT, ALU_REQ, HOLD_EXEC;
  logic [1:0] WB_CNT_I, WR_CNT_I;
  logic       ADR_FIRST_I, ADR_BETWEEN_I, WR_RDY, ABORT;
  logic [2:0] STATE;
  logic       BUSY, WB_STB, ADR_STB, WR_REQ, DONE, ABORTED;
  logic [0:0] WB_IDX, WR_IDX;
  logic [10:0] obs;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [10:0] v;
    bit          rdy;
    bit          is_wr;
  } entry_t;
  entry_t trace[$];

  wf68k30l_exec_wb_seq #(.MAX_WB(MAX_WB), .MAX_WR(MAX_WR)) dut (
    .CLK(CLK), .RESET_CPU(RESET_CPU), .ALU_INIT(ALU_INIT), .ALU_REQ(ALU_REQ),
    .HOLD_EXEC(HOLD_EXEC), .WB_CNT_I(WB_CNT_I), .WR_CNT_I(WR_CNT_I),
    .ADR_FIRST_I(ADR_FIRST_I), .ADR_BETWEEN_I(ADR_BETWEEN_I), .WR_RDY(WR_RDY),
    .ABORT(ABORT), .STATE(STATE), .BUSY(BUSY), .WB_STB(WB_STB), .WB_IDX(WB_IDX),
    .ADR_STB(ADR_STB), .WR_REQ(WR_REQ), .WR_IDX(WR_IDX), .DONE(DONE), .ABORTED(ABORTED)
  );

  always #5 CLK = ~CLK;

  assign obs = {STATE, BUSY, WB_STB, WB_IDX, ADR_STB, WR_REQ, WR_IDX, DONE, ABORTED};

  // Expected output vector for a given visible state
  function automatic logic [10:0] mk(input int st, input bit wbs, input int wbi, input bit adr,
                                     input bit wrq, input int wri, input bit dn, input bit ab);
    return {3'(st), (st != 0), wbs, 1'(wbi), adr, wrq, 1'(wri), dn, ab};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ALU_INIT = 1'b0; ALU_REQ = 1'b0; HOLD_EXEC = 1'b0; WB_CNT_I = 2'd0; WR_CNT_I = 2'd0;
    ADR_FIRST_I = 1'b0; ADR_BETWEEN_I = 1'b0; WR_RDY = 1'b0; ABORT = 1'b0;
  endtask

  // One instruction: init, optional hold, accept, walk the expected trace, completion
  task automatic run_txn(input int wb, input int wr, input bit af, input bit ab, input int nbeat,
                         input int hold, input bit b2b, input string tag);
    int wbs, wrs;
    logic [10:0] exp_v;
    wbs = (wb > MAX_WB) ? MAX_WB : wb;
    wrs = (wr > MAX_WR) ? MAX_WR : wr;
    trace.delete();
    for (int k = 0; k < wbs; k++) trace.push_back('{mk(3, 1, k, 0, 0, 0, 0, 0), 1'b0, 1'b0});
    if (wrs > 0 && af) trace.push_back('{mk(2, 0, 0, 1, 0, 0, 0, 0), 1'b0, 1'b0});
    for (int b = 0; b < wrs; b++) begin
      if (b > 0 && ab) trace.push_back('{mk(2, 0, 0, 1, 0, 0, 0, 0), 1'b0, 1'b0});
      for (int c = 0; c < nbeat; c++)
        trace.push_back('{mk(4, 0, 0, 0, 1, b, 0, 0), (c == nbeat - 1), 1'b1});
    end

    idle_inputs();
    ALU_INIT = 1'b1;
    step();
    total++;
    if (obs !== mk(1, 0, 0, 0, 0, 0, 0, 0)) begin
      bad++; $display("FAIL %s_init: got %h want %h", tag, obs, mk(1, 0, 0, 0, 0, 0, 0, 0));
    end
    ALU_INIT = 1'b0;
    for (int h = 0; h < hold; h++) begin
      ALU_REQ = 1'b1; HOLD_EXEC = 1'b1;
      WB_CNT_I = 2'($urandom_range(0, 3)); WR_CNT_I = 2'($urandom_range(0, 3));
      ADR_FIRST_I = 1'($urandom); ADR_BETWEEN_I = 1'($urandom);
      step();
      total++;
      if (obs !== mk(1, 0, 0, 0, 0, 0, 0, 0)) begin
        bad++; $display("FAIL %s_hold%0d: got %h want %h", tag, h, obs, mk(1, 0, 0, 0, 0, 0, 0, 0));
      end
    end
    ALU_REQ = 1'b1; HOLD_EXEC = 1'b0;
    WB_CNT_I = 2'(wb); WR_CNT_I = 2'(wr); ADR_FIRST_I = af; ADR_BETWEEN_I = ab;
    step();
    foreach (trace[i]) begin
      total++;
      if (obs !== trace[i].v) begin
        bad++; $display("FAIL %s_cyc%0d: got %h want %h", tag, i, obs, trace[i].v);
      end
      ALU_INIT = 1'($urandom); ALU_REQ = 1'($urandom); HOLD_EXEC = 1'($urandom);
      WB_CNT_I = 2'($urandom_range(0, 3)); WR_CNT_I = 2'($urandom_range(0, 3));
      ADR_FIRST_I = 1'($urandom); ADR_BETWEEN_I = 1'($urandom);
      if (trace[i].is_wr) WR_RDY = trace[i].rdy;
      else                WR_RDY = 1'($urandom);
`ifndef WF68K30L_EXEC_WB_ABORT_EN
      ABORT = 1'($urandom);
`endif
      step();
    end
    exp_v = mk(0, 0, 0, 0, 0, 0, 1, 0);
    total++;
    if (obs !== exp_v) begin
      bad++; $display("FAIL %s_done: got %h want %h", tag, obs, exp_v);
    end
    idle_inputs();
    ALU_INIT = b2b;
    step();
    exp_v = b2b ? mk(1, 0, 0, 0, 0, 0, 0, 0) : mk(0, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if (obs !== exp_v) begin
      bad++; $display("FAIL %s_after: got %h want %h", tag, obs, exp_v);
    end
    ALU_INIT = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RESET_CPU = 1'b1;
    step(); step();
    total++;
    if (obs !== 11'd0) begin bad++; $display("FAIL reset: got %h want %h", obs, 11'd0); end
    RESET_CPU = 1'b0;
    step();
    total++;
    if (obs !== 11'd0) begin bad++; $display("FAIL reset_idle: got %h want %h", obs, 11'd0); end
  endtask

  task automatic test_reset_mid_write();
    idle_inputs();
    ALU_INIT = 1'b1; step();
    ALU_INIT = 1'b0; ALU_REQ = 1'b1; WR_CNT_I = 2'd2; step();
    ALU_REQ = 1'b0;
    total++;
    if (obs !== mk(4, 0, 0, 0, 1, 0, 0, 0)) begin
      bad++; $display("FAIL rst_mid_pre: got %h want %h", obs, mk(4, 0, 0, 0, 1, 0, 0, 0));
    end
    RESET_CPU = 1'b1; WR_RDY = 1'b1; step();
    total++;
    if (obs !== 11'd0) begin bad++; $display("FAIL rst_mid: got %h want %h", obs, 11'd0); end
    RESET_CPU = 1'b0; WR_RDY = 1'b0; step();
    total++;
    if (obs !== 11'd0) begin bad++; $display("FAIL rst_mid_after: got %h want %h", obs, 11'd0); end
  endtask

  task automatic test_writeback();
    run_txn(2, 0, 0, 0, 1, 0, 0, "cas2_fail");
    run_txn(3, 1, 0, 0, 1, 0, 0, "wb_sat");
  endtask

  task automatic test_write_adr();
    run_txn(0, 2, 1, 1, 3, 0, 0, "adr_slow");
    run_txn(0, 2, 1, 0, 1, 0, 0, "cas2_ok");
    run_txn(0, 2, 0, 1, 2, 0, 0, "bitfield");
  endtask

  task automatic test_hold();
    run_txn(1, 1, 0, 0, 1, 4, 0, "hold");
  endtask

  task automatic test_back_to_back();
    run_txn(0, 0, 0, 0, 1, 0, 1, "movem_inh");
    run_txn(1, 0, 0, 0, 1, 0, 0, "b2b_next");
  endtask

  task automatic test_random();
    for (int t = 0; t < 25; t++)
      run_txn($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
              $urandom_range(1, 3), $urandom_range(0, 2), 1'($urandom), "rnd");
  endtask

  task automatic test_abort();
    idle_inputs();
    ALU_INIT = 1'b1; step();
    ALU_INIT = 1'b0; ALU_REQ = 1'b1; WR_CNT_I = 2'd2; step();
    ALU_REQ = 1'b0;
    total++;
    if (obs !== mk(4, 0, 0, 0, 1, 0, 0, 0)) begin
      bad++; $display("FAIL abort_pre: got %h want %h", obs, mk(4, 0, 0, 0, 1, 0, 0, 0));
    end
    WR_RDY = 1'b1; ABORT = 1'b1; step();
    WR_RDY = 1'b0; ABORT = 1'b0;
`ifdef WF68K30L_EXEC_WB_ABORT_EN
    total++;
    if (obs !== mk(0, 0, 0, 0, 0, 0, 0, 1)) begin
      bad++; $display("FAIL abort_pulse: got %h want %h", obs, mk(0, 0, 0, 0, 0, 0, 0, 1));
    end
    for (int i = 0; i < 3; i++) begin
      WR_RDY = 1'($urandom);
      step();
      total++;
      if (obs !== 11'd0) begin bad++; $display("FAIL abort_idle%0d: got %h want %h", i, obs, 11'd0); end
    end
    WR_RDY = 1'b0; ABORT = 1'b1; ALU_INIT = 1'b1; step();
    total++;
    if (obs !== mk(1, 0, 0, 0, 0, 0, 0, 0)) begin
      bad++; $display("FAIL abort_in_idle: got %h want %h", obs, mk(1, 0, 0, 0, 0, 0, 0, 0));
    end
    ALU_INIT = 1'b0; step();
    total++;
    if (obs !== mk(0, 0, 0, 0, 0, 0, 0, 1)) begin
      bad++; $display("FAIL abort_exec: got %h want %h", obs, mk(0, 0, 0, 0, 0, 0, 0, 1));
    end
    ABORT = 1'b0; step();
    total++;
    if (obs !== 11'd0) begin bad++; $display("FAIL abort_clear: got %h want %h", obs, 11'd0); end
`else
    total++;
    if (obs !== mk(4, 0, 0, 0, 1, 1, 0, 0)) begin
      bad++; $display("FAIL noabort_beat1: got %h want %h", obs, mk(4, 0, 0, 0, 1, 1, 0, 0));
    end
    WR_RDY = 1'b1; ABORT = 1'b1; step();
    WR_RDY = 1'b0; ABORT = 1'b0;
    total++;
    if (obs !== mk(0, 0, 0, 0, 0, 0, 1, 0)) begin
      bad++; $display("FAIL noabort_done: got %h want %h", obs, mk(0, 0, 0, 0, 0, 0, 1, 0));
    end
    step();
    total++;
    if (obs !== 11'd0) begin bad++; $display("FAIL noabort_idle: got %h want %h", obs, 11'd0); end
`endif
  endtask

  initial begin
    idle_inputs();
    RESET_CPU = 1'b1;
    test_reset();
    test_reset_mid_write();
    test_writeback();
    test_write_adr();
    test_hold();
    test_back_to_back();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
